// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus controller.
// Optional feature macro used by this slice: MEM_BUS_TIMEOUT_EN (ACCESS timeout).
package mem_bus_pkg;

    localparam int unsigned NUM_TGT = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned CNT_W   = 8;

    localparam int unsigned TGT_BRAM   = 0;
    localparam int unsigned TGT_SRAM   = 1;
    localparam int unsigned TGT_FLASH  = 2;
    localparam int unsigned TGT_PERIPH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Latched CPU request as presented to the targets
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [BE_W-1:0]   be;
    } bus_req_t;

    // True when exactly one bit of a target select vector is set
    function automatic logic is_onehot(input logic [NUM_TGT-1:0] v);
        return (v != '0) && ((v & (v - NUM_TGT'(1))) == '0);
    endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// ACCESS-phase watchdog counter; only compiled with MEM_BUS_TIMEOUT_EN defined.
`ifdef MEM_BUS_TIMEOUT_EN
module mem_bus_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired_c
);

    logic [CNT_W-1:0] count_q;

    // Count ACCESS cycles without ack; restart on each ACCESS entry
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_c = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/memory_decoder.sv
// Address decoder: 64 KiB regions at 0x0000_xxxx BRAM, 0x0001 SRAM, 0x0002 FLASH,
// 0x0003 PERIPH; anything else is a decode error.
module memory_decoder
    import mem_bus_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_TGT-1:0] sel,
    output logic               error
);

    // Only the region bits participate in the decode
    logic unused_offset;
    assign unused_offset = ^addr[15:0];

    // Region lookup on the upper address half
    always_comb begin
        sel   = '0;
        error = 1'b0;
        case (addr[31:16])
            16'h0000: sel[TGT_BRAM]   = 1'b1;
            16'h0001: sel[TGT_SRAM]   = 1'b1;
            16'h0002: sel[TGT_FLASH]  = 1'b1;
            16'h0003: sel[TGT_PERIPH] = 1'b1;
            default:  error           = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Single-outstanding bus master from the CPU load/store port to four memory targets.
// Define MEM_BUS_TIMEOUT_EN to abort unacknowledged accesses after TIMEOUT_CYCLES.
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_valid,
    output logic                      cpu_req_ready,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic                      cpu_we,
    input  logic [BE_W-1:0]           cpu_be,
    output logic                      cpu_resp_valid,
    input  logic                      cpu_resp_ready,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_resp_error,
    output logic [NUM_TGT-1:0]        tgt_req,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wdata,
    output logic                      tgt_we,
    output logic [BE_W-1:0]           tgt_be,
    input  logic [NUM_TGT-1:0]        tgt_ack,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata
);

    state_t              state_q, state_d;
    bus_req_t            req_q, req_d;
    logic [NUM_TGT-1:0]  tgt_req_d;
    logic                resp_valid_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                resp_error_d;

    logic [NUM_TGT-1:0]  dec_sel;
    logic                dec_err;
    logic                dec_ok_c;
    logic                ack_hit_c;
    logic [DATA_W-1:0]   ack_rdata_c;
    logic                timeout_c;

    memory_decoder u_decoder (
        .addr  (req_q.addr),
        .sel   (dec_sel),
        .error (dec_err)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    logic timer_expired;

    mem_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == ST_DECODE),
        .inc       ((state_q == ST_ACCESS) && !ack_hit_c),
        .expired_c (timer_expired)
    );

    assign timeout_c = (state_q == ST_ACCESS) && timer_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_c          = 1'b0;
`endif

    assign cpu_req_ready = (state_q == ST_IDLE);
    assign dec_ok_c      = !dec_err && is_onehot(dec_sel);
    assign ack_hit_c     = |(tgt_ack & tgt_req);

    assign tgt_addr  = req_q.addr;
    assign tgt_wdata = req_q.wdata;
    assign tgt_we    = req_q.we;
    assign tgt_be    = req_q.be;

    // Read data of the currently strobed target
    always_comb begin
        ack_rdata_c = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (tgt_req[i]) begin
                ack_rdata_c = ack_rdata_c | tgt_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_req_valid)            state_d = ST_DECODE;
            ST_DECODE: state_d = dec_ok_c ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (ack_hit_c || timeout_c)   state_d = ST_RESP;
            ST_RESP:   if (cpu_resp_ready)           state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs
    always_comb begin
        req_d        = req_q;
        tgt_req_d    = tgt_req;
        resp_valid_d = cpu_resp_valid;
        rdata_d      = cpu_rdata;
        resp_error_d = cpu_resp_error;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    req_d = '{addr: cpu_addr, wdata: cpu_wdata, we: cpu_we, be: cpu_be};
                end
            end
            ST_DECODE: begin
                if (dec_ok_c) begin
                    tgt_req_d = dec_sel;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    rdata_d      = '0;
                end
            end
            ST_ACCESS: begin
                // A same-cycle ack takes priority over timeout expiry
                if (ack_hit_c) begin
                    tgt_req_d    = '0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    rdata_d      = req_q.we ? '0 : ack_rdata_c;
                end else if (timeout_c) begin
                    tgt_req_d    = '0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    rdata_d      = '0;
                end
            end
            ST_RESP: begin
                if (cpu_resp_ready) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q          <= '0;
            tgt_req        <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_resp_error <= 1'b0;
        end else begin
            req_q          <= req_d;
            tgt_req        <= tgt_req_d;
            cpu_resp_valid <= resp_valid_d;
            cpu_rdata      <= rdata_d;
            cpu_resp_error <= resp_error_d;
        end
    end

endmodule
